// File: rtl/alu_src_ctrl_fsm.sv
// Multicycle control FSM: steps add/sub/and/or/slt/addi/lw/sw/beq/j through fetch..writeback.
// Define ALU_SRC_CTRL_BNE_EN to add bne (opcode 0x05) through a BRANCH_NE state.
module alu_src_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 2  // extra memory wait cycles, 0..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       alu_out_write,
    output logic [1:0] pc_source,
    output logic       halt,
    output logic [3:0] state_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef ALU_SRC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

    // The low nibble is the debug code on state_out. ADDR shares EXEC_I's code (identical
    // outputs, told apart by the stable opcode) and BRANCH_NE shares BRANCH's, so 18 states fit.
    typedef enum logic [4:0] {
        S_RST         = 5'h00,
        S_FETCH       = 5'h01,
        S_FETCH_WAIT  = 5'h02,
        S_FETCH_LATCH = 5'h03,
        S_DECODE      = 5'h04,
        S_EXEC_R      = 5'h05,
        S_WB_R        = 5'h06,
        S_EXEC_I      = 5'h07,
        S_WB_I        = 5'h08,
        S_MEM_RD      = 5'h09,
        S_MEM_WAIT    = 5'h0A,
        S_WB_M        = 5'h0B,
        S_MEM_WR      = 5'h0C,
        S_BRANCH      = 5'h0D,
        S_JUMP        = 5'h0E,
        S_HALT        = 5'h0F,
        S_ADDR        = 5'h17,
        S_BRANCH_NE   = 5'h1D
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic [1:0] pc_source;
        logic       halt;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{alu_src_b: 2'b01, default: '0};

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q;

    function automatic logic [2:0] r_alu_op(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NONE;
        endcase
    endfunction

    // Moore output decode for a state; the branch pc_write is added combinationally below.
    function automatic ctrl_t ctrl_of(input state_e s, input logic [5:0] f);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S_FETCH_LATCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_a = 1'b0;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
                c.pc_source = 2'b00;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b     = 2'b11;
                c.alu_op        = ALU_ADD;
                c.alu_out_write = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b10;
                c.alu_op        = r_alu_op(f);
                c.alu_out_write = 1'b1;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_op        = ALU_ADD;
                c.alu_out_write = 1'b1;
            end
            S_WB_I:                c.reg_write = 1'b1;
            S_MEM_RD, S_MEM_WAIT:  c.iord = 1'b1;
            S_WB_M: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.iord   = 1'b1;
                c.mem_wr = 1'b1;
            end
            S_BRANCH, S_BRANCH_NE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_SUB;
                c.pc_source = 2'b01;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_HALT:  c.halt = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RST:         state_d = S_FETCH;
            S_FETCH:       state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_FETCH_LATCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_FETCH_LATCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef ALU_SRC_CTRL_BNE_EN
                    OP_BNE:        state_d = S_BRANCH_NE;
`endif
                    default:       state_d = S_HALT;
                endcase
            end
            S_EXEC_R:      state_d = (r_alu_op(funct) == ALU_NONE) ? S_HALT : S_WB_R;
            S_EXEC_I:      state_d = S_WB_I;
            S_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_RD;
                else if (opcode == OP_SW) state_d = S_MEM_WR;
                else                      state_d = S_HALT;
            end
            S_MEM_RD:      state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_WB_M;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WB_R, S_WB_I, S_WB_M, S_MEM_WR,
            S_BRANCH, S_BRANCH_NE, S_JUMP:
                           state_d = S_FETCH;
            S_HALT:        state_d = S_HALT;
            default:       state_d = S_HALT;
        endcase
        if (state_d == S_FETCH || state_d == S_MEM_RD) cnt_d = WAIT_LOAD;
    end

    // Outputs are registered from the next state, so they are Moore in timing and the
    // asynchronous reset clears every strobe at once rather than at the next edge.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_of(state_d, funct);
        end
    end

    always_comb begin
        pc_write = ctrl_q.pc_write;
        if (state_q == S_BRANCH) pc_write = alu_zero;
`ifdef ALU_SRC_CTRL_BNE_EN
        if (state_q == S_BRANCH_NE) pc_write = ~alu_zero;
`endif
    end

    assign iord          = ctrl_q.iord;
    assign mem_wr        = ctrl_q.mem_wr;
    assign ir_write      = ctrl_q.ir_write;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign alu_out_write = ctrl_q.alu_out_write;
    assign pc_source     = ctrl_q.pc_source;
    assign halt          = ctrl_q.halt;
    assign state_out     = state_q[3:0];

endmodule

// File: tb/tb_alu_src_ctrl_fsm.sv
// Bench for alu_src_ctrl_fsm: two instances (MEM_WAIT = 2 and 0) checked cycle by cycle
// against a per-instruction expected output trace built from the instruction rules.
module tb_alu_src_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic [1:0] pc_source;
        logic       halt;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       az;
        int         k;      // instance: 0 -> MEM_WAIT 2, 1 -> MEM_WAIT 0
        int         n_wait; // number of memory waits of length W
        int         base;   // cycles besides the waits, FETCH issue cycle excluded
        logic       halts;
    } vec_t;

`ifdef ALU_SRC_CTRL_BNE_EN
    localparam logic BNE_HALTS = 1'b0;
`else
    localparam logic BNE_HALTS = 1'b1;
`endif

    logic       clk;
    logic       rst [2];
    logic [5:0] opc [2];
    logic [5:0] fnc [2];
    logic       az  [2];

    wire       pc_write_w      [2];
    wire       iord_w          [2];
    wire       mem_wr_w        [2];
    wire       ir_write_w      [2];
    wire       reg_write_w     [2];
    wire       reg_dst_w       [2];
    wire       mem_to_reg_w    [2];
    wire       alu_src_a_w     [2];
    wire [1:0] alu_src_b_w     [2];
    wire [2:0] alu_op_w        [2];
    wire       alu_out_write_w [2];
    wire [1:0] pc_source_w     [2];
    wire       halt_w          [2];
    wire [3:0] state_out_w     [2];

    int    n_chk;
    int    n_fail;
    outs_t exp_q [$];
    vec_t  vecs  [$];

    alu_src_ctrl_fsm #(.MEM_WAIT(2)) u_dut_w2 (
        .clk(clk), .reset(rst[0]), .opcode(opc[0]), .funct(fnc[0]), .alu_zero(az[0]),
        .pc_write(pc_write_w[0]), .iord(iord_w[0]), .mem_wr(mem_wr_w[0]),
        .ir_write(ir_write_w[0]), .reg_write(reg_write_w[0]), .reg_dst(reg_dst_w[0]),
        .mem_to_reg(mem_to_reg_w[0]), .alu_src_a(alu_src_a_w[0]), .alu_src_b(alu_src_b_w[0]),
        .alu_op(alu_op_w[0]), .alu_out_write(alu_out_write_w[0]), .pc_source(pc_source_w[0]),
        .halt(halt_w[0]), .state_out(state_out_w[0])
    );

    alu_src_ctrl_fsm #(.MEM_WAIT(0)) u_dut_w0 (
        .clk(clk), .reset(rst[1]), .opcode(opc[1]), .funct(fnc[1]), .alu_zero(az[1]),
        .pc_write(pc_write_w[1]), .iord(iord_w[1]), .mem_wr(mem_wr_w[1]),
        .ir_write(ir_write_w[1]), .reg_write(reg_write_w[1]), .reg_dst(reg_dst_w[1]),
        .mem_to_reg(mem_to_reg_w[1]), .alu_src_a(alu_src_a_w[1]), .alu_src_b(alu_src_b_w[1]),
        .alu_op(alu_op_w[1]), .alu_out_write(alu_out_write_w[1]), .pc_source(pc_source_w[1]),
        .halt(halt_w[1]), .state_out(state_out_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mw_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic outs_t get(input int k);
        outs_t o;
        o.pc_write      = pc_write_w[k];
        o.iord          = iord_w[k];
        o.mem_wr        = mem_wr_w[k];
        o.ir_write      = ir_write_w[k];
        o.reg_write     = reg_write_w[k];
        o.reg_dst       = reg_dst_w[k];
        o.mem_to_reg    = mem_to_reg_w[k];
        o.alu_src_a     = alu_src_a_w[k];
        o.alu_src_b     = alu_src_b_w[k];
        o.alu_op        = alu_op_w[k];
        o.alu_out_write = alu_out_write_w[k];
        o.pc_source     = pc_source_w[k];
        o.halt          = halt_w[k];
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic outs_t idle();
        outs_t o;
        o = '0;
        o.alu_src_b = 2'b01;
        return o;
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b001;
            6'h22:   return 3'b010;
            6'h24:   return 3'b011;
            6'h25:   return 3'b100;
            6'h2A:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic outs_t alu_imm();
        outs_t o;
        o = idle();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = 3'b001; o.alu_out_write = 1'b1;
        return o;
    endfunction

    function automatic outs_t branch_step(input logic take);
        outs_t o;
        o = idle();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 3'b010;
        o.pc_source = 2'b01; o.pc_write = take;
        return o;
    endfunction

    // Expected outputs of one instruction, one entry per cycle, starting with the FETCH cycle.
    task automatic build(input int mw, input logic [5:0] op, input logic [5:0] fn,
                         input logic zero, output logic halts);
        outs_t o;
        halts = 1'b0;
        exp_q.delete();
        exp_q.push_back(idle());
        for (int i = 0; i <= mw; i++) exp_q.push_back(idle());
        o = idle(); o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_op = 3'b001;
        exp_q.push_back(o);
        o = idle(); o.alu_src_b = 2'b11; o.alu_op = 3'b001; o.alu_out_write = 1'b1;
        exp_q.push_back(o);
        case (op)
            6'h00: begin
                o = idle(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_op = r_op(fn); o.alu_out_write = 1'b1;
                exp_q.push_back(o);
                if (r_op(fn) == 3'b000) halts = 1'b1;
                else begin
                    o = idle(); o.reg_write = 1'b1; o.reg_dst = 1'b1;
                    exp_q.push_back(o);
                end
            end
            6'h08: begin
                exp_q.push_back(alu_imm());
                o = idle(); o.reg_write = 1'b1;
                exp_q.push_back(o);
            end
            6'h23: begin
                exp_q.push_back(alu_imm());
                o = idle(); o.iord = 1'b1;
                for (int i = 0; i <= mw + 1; i++) exp_q.push_back(o);
                o = idle(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
                exp_q.push_back(o);
            end
            6'h2B: begin
                exp_q.push_back(alu_imm());
                o = idle(); o.iord = 1'b1; o.mem_wr = 1'b1;
                exp_q.push_back(o);
            end
            6'h04: exp_q.push_back(branch_step(zero));
            6'h02: begin
                o = idle(); o.pc_source = 2'b10; o.pc_write = 1'b1;
                exp_q.push_back(o);
            end
            6'h05: begin
                if (BNE_HALTS) halts = 1'b1;
                else exp_q.push_back(branch_step(~zero));
            end
            default: halts = 1'b1;
        endcase
        if (halts) begin
            o = idle(); o.halt = 1'b1;
            for (int i = 0; i < 4; i++) exp_q.push_back(o);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Leaves the instance just after the release edge, i.e. in its FETCH cycle.
    task automatic do_reset(input int k);
        @(negedge clk);
        rst[k] = 1'b0;
        #2;
        check($sformatf("u%0d reset outs", k), get(k), idle());
        @(negedge clk);
        rst[k] = 1'b1;
        @(posedge clk);
    endtask

    task automatic run(input int k, input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, output logic halts);
        build(mw_of(k), op, fn, zero, halts);
        opc[k] = op; fnc[k] = fn; az[k] = zero;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("u%0d op%02h fn%02h z%0b cyc%0d", k, op, fn, zero, i), get(k), exp_q[i]);
            @(posedge clk);
        end
    endtask

    // Cycles between consecutive ir_write pulses, less the FETCH issue cycle.
    task automatic measure_gap(input int k, input int exp_cyc, input string name);
        int    first;
        outs_t o;
        first = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            o = get(k);
            if (o.ir_write) begin
                if (first < 0) first = cyc;
                else begin
                    check(name, cyc - first - 1, exp_cyc);
                    return;
                end
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: no second ir_write within 100 cycles, expected gap %0d", name, exp_cyc);
    endtask

    function automatic int find_strobe_idx(input bit want_mem_wr);
        for (int i = 0; i < exp_q.size(); i++)
            if (want_mem_wr ? exp_q[i].mem_wr : (exp_q[i].pc_source == 2'b01)) return i;
        return 0;
    endfunction

    initial begin
        logic  halted;
        logic  dummy;
        outs_t o;
        int    idx;
        logic [5:0] op, fn;

        n_chk = 0; n_fail = 0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; opc[k] = 6'h00; fnc[k] = 6'h20; az[k] = 1'b0;
        end

        //             name         op     fn     az  k  nw base halts
        vecs.push_back('{"add",     6'h00, 6'h20, 0, 0, 1, 4, 1'b0});
        vecs.push_back('{"sub",     6'h00, 6'h22, 1, 0, 1, 4, 1'b0});
        vecs.push_back('{"and",     6'h00, 6'h24, 0, 1, 1, 4, 1'b0});
        vecs.push_back('{"or",      6'h00, 6'h25, 0, 0, 1, 4, 1'b0});
        vecs.push_back('{"slt",     6'h00, 6'h2A, 1, 0, 1, 4, 1'b0});
        vecs.push_back('{"addi",    6'h08, 6'h11, 0, 0, 1, 4, 1'b0});
        vecs.push_back('{"lw_w0",   6'h23, 6'h00, 0, 1, 2, 5, 1'b0});
        vecs.push_back('{"lw_w2",   6'h23, 6'h3F, 1, 0, 2, 5, 1'b0});
        vecs.push_back('{"sw",      6'h2B, 6'h20, 0, 0, 1, 4, 1'b0});
        vecs.push_back('{"beq_t",   6'h04, 6'h00, 1, 0, 1, 3, 1'b0});
        vecs.push_back('{"beq_nt",  6'h04, 6'h00, 0, 0, 1, 3, 1'b0});
        vecs.push_back('{"j",       6'h02, 6'h00, 0, 1, 1, 3, 1'b0});
        vecs.push_back('{"bne",     6'h05, 6'h00, 0, 0, 1, 3, BNE_HALTS});
        vecs.push_back('{"op3f",    6'h3F, 6'h20, 0, 0, 0, 0, 1'b1});
        vecs.push_back('{"fn00",    6'h00, 6'h00, 0, 1, 0, 0, 1'b1});

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            do_reset(vecs[i].k);
            run(vecs[i].k, vecs[i].op, vecs[i].fn, vecs[i].az, halted);
            @(negedge clk);
            o = get(vecs[i].k);
            check({vecs[i].name, " halt"}, o.halt, vecs[i].halts);
            if (!vecs[i].halts) begin
                do_reset(vecs[i].k);
                measure_gap(vecs[i].k, vecs[i].base + vecs[i].n_wait * (mw_of(vecs[i].k) + 1),
                            {vecs[i].name, " cycles"});
            end
        end

        // Halt stays set with a legal instruction presented, and reset clears it.
        do_reset(0);
        run(0, 6'h3F, 6'h00, 1'b0, halted);
        opc[0] = 6'h00; fnc[0] = 6'h20;
        o = idle(); o.halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("halt sticky %0d", i), get(0), o);
        end

        // Asynchronous reset in the middle of MEM_WR drops mem_wr without a clock edge.
        do_reset(0);
        build(2, 6'h2B, 6'h00, 1'b0, dummy);
        idx = find_strobe_idx(1'b1);
        opc[0] = 6'h2B; fnc[0] = 6'h00; az[0] = 1'b0;
        repeat (idx) @(posedge clk);
        #2;
        o = get(0);
        check("sw mem_wr before reset", o.mem_wr, 1'b1);
        #1 rst[0] = 1'b0;
        #1;
        check("async reset outs", get(0), idle());
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk);
        run(0, 6'h02, 6'h00, 1'b0, halted);

        // pc_write follows alu_zero combinationally inside BRANCH.
        do_reset(0);
        build(2, 6'h04, 6'h00, 1'b0, dummy);
        idx = find_strobe_idx(1'b0);
        opc[0] = 6'h04; az[0] = 1'b0;
        repeat (idx) @(posedge clk);
        #2;
        o = get(0);
        check("beq pc_write z0", o.pc_write, 1'b0);
        az[0] = 1'b1;
        #1;
        o = get(0);
        check("beq pc_write z1", o.pc_write, 1'b1);
        az[0] = 1'b0;
        #1;
        o = get(0);
        check("beq pc_write z0 again", o.pc_write, 1'b0);
        @(posedge clk);

        // Randomized back-to-back instructions on both instances.
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            for (int n = 0; n < 30; n++) begin
                fn = 6'($urandom);
                case ($urandom_range(0, 11))
                    0:  begin op = 6'h00; fn = 6'h20; end
                    1:  begin op = 6'h00; fn = 6'h22; end
                    2:  begin op = 6'h00; fn = 6'h24; end
                    3:  begin op = 6'h00; fn = 6'h25; end
                    4:  begin op = 6'h00; fn = 6'h2A; end
                    5:  op = 6'h08;
                    6:  op = 6'h23;
                    7:  op = 6'h2B;
                    8:  op = 6'h04;
                    9:  op = 6'h02;
                    10: op = 6'h05;
                    default: op = 6'($urandom);
                endcase
                run(k, op, fn, 1'($urandom), halted);
                if (halted) do_reset(k);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_src_ctrl_fsm.md
Name: alu_src_ctrl_fsm

Overview:
- Multicycle control FSM that produces the datapath select and write-enable signals.
- It drives the operand-B select (SE16_32 / const 4 / RegB / SL2), the operand-A select, the ALU operation, the PC source and all register and memory write strobes.
- It sits between the instruction register fields (opcode, funct) and the datapath muxes.
- It steps each instruction through fetch, decode, execute, memory and writeback.
- Supported subset: R-type add/sub/and/or/slt, addi, lw, sw, beq, j.

Parameters:
- MEM_WAIT, 2, extra cycles held after issuing a memory read before the data is valid (0..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, same cycle
- pc_write  out  1  PC load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_wr  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  operand A: 0 = PC, 1 = RegA
- alu_src_b  out  2  operand B: 00 = SE16_32, 01 = const 4, 10 = RegB, 11 = SL2
- alu_op  out  3  ALU operation: 001 add, 010 sub, 011 and, 100 or, 111 slt
- alu_out_write  out  1  ALUOut load enable
- pc_source  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target
- halt  out  1  illegal instruction, sticky
- state_out  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - While reset = 0: state = RST; all outputs 0 except alu_src_b = 01.
  - Reset is asynchronous. Assertion mid-instruction aborts the instruction immediately; no write strobe may be seen after the asynchronous assertion.
  - First rising edge after release: RST -> FETCH.
- Outputs are Moore, decoded from the state register. Exception: pc_write in BRANCH is a combinational function of alu_zero.
- Any output not listed for a state is 0 (alu_src_b defaults to 01).
- A wait counter (4 bits) loads MEM_WAIT on entry to FETCH or MEM_RD and decrements in the matching wait state. The wait state exits when the counter is 0. With MEM_WAIT = 0 the wait state lasts exactly one cycle.
- State outputs and transitions:
  - FETCH: iord = 0. -> FETCH_WAIT.
  - FETCH_WAIT: iord = 0. Hold until count = 0, then -> FETCH_LATCH.
  - FETCH_LATCH: ir_write = 1; alu_src_a = 0, alu_src_b = 01, alu_op = 001, pc_source = 00, pc_write = 1. -> DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 001, alu_out_write = 1 (precomputes the branch target).
    - opcode 0x00 -> EXEC_R
    - 0x08 -> EXEC_I
    - 0x23 or 0x2B -> ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - anything else -> HALT
  - EXEC_R: alu_src_a = 1, alu_src_b = 10, alu_out_write = 1.
    - alu_op from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
    - Any other funct -> HALT (no write). Otherwise -> WB_R.
  - WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
  - EXEC_I: alu_src_a = 1, alu_src_b = 00, alu_op = 001, alu_out_write = 1. -> WB_I.
  - WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
  - ADDR: alu_src_a = 1, alu_src_b = 00, alu_op = 001, alu_out_write = 1. -> MEM_RD if lw, MEM_WR if sw.
  - MEM_RD: iord = 1. -> MEM_WAIT_S, hold until count = 0, then -> WB_M.
  - WB_M: reg_write = 1, reg_dst = 0, mem_to_reg = 1. -> FETCH.
  - MEM_WR: iord = 1, mem_wr = 1 for exactly one cycle. -> FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 10, alu_op = 010, pc_source = 01, pc_write = alu_zero. -> FETCH.
  - JUMP: pc_source = 10, pc_write = 1. -> FETCH.
  - HALT: halt = 1; all strobes 0. Remains in HALT until reset.
- Each instruction issues at most one register or memory write.
- Total cycles, with W = MEM_WAIT + 1:
  - R-type / addi: W + 4
  - lw: 2W + 5
  - sw: W + 4
  - beq, j: W + 3

Optional Feature:
- Macro: ALU_SRC_CTRL_BNE_EN.
- When defined:
  - opcode 0x05 (bne) in DECODE -> BRANCH_NE.
  - BRANCH_NE has the same outputs as BRANCH, except pc_write = ~alu_zero. -> FETCH.
- When undefined: opcode 0x05 -> HALT.

Test Plan:
- MEM_WAIT = 2, reset released, IR gets add (opcode 0x00, funct 0x20) -> the state sequence and output strobes match the 7 cycles of an R-type instruction; reg_write = 1, reg_dst = 1 only in the last cycle; alu_src_b = 10 in EXEC_R.
- lw (0x23), MEM_WAIT = 0 -> 7 cycles; alu_src_b = 00 in ADDR; iord = 1 in MEM_RD; mem_to_reg = 1 with reg_write = 1 in WB_M.
- beq with alu_zero = 1, then beq with alu_zero = 0 -> pc_write = 1 / 0 respectively in BRANCH; pc_source = 01; alu_src_b = 11 in DECODE.
- opcode 0x3F, or R-type with funct 0x00 -> halt = 1 permanently, no write strobes; reset = 0 clears it to RST.
- Drop reset to 0 asynchronously during MEM_WR -> mem_wr falls without waiting for a clock edge; state = RST; first release edge -> FETCH.
- bne (0x05) with alu_zero = 0 -> pc_write = 1 with the macro defined; halt = 1 without it.
